// File: rtl/ozdefs.sv
`default_nettype none
// ============================================================================
// Module : ozdefs
// Brief  : Shared LTSSM state encoding, lane command set and helpers.
// Rev    : 1.0
// ============================================================================
package ozdefs;

    typedef enum logic [3:0] {
        DETECT_QUIET             = 4'd0,
        DETECT_ACTIVE            = 4'd1,
        POLLING_ACTIVE           = 4'd2,
        POLLING_ACTIVE_START_TS1 = 4'd3,
        POLLING_CONFIG           = 4'd4,
        CONFIG_LINKWIDTH_START   = 4'd5,
        L0                       = 4'd6,
        DISABLED                 = 4'd7
    } LTSSM_State;

    // Commands from the link arbiter that override a lane's own progression.
    typedef enum logic [1:0] {
        LANE_CMD_NONE    = 2'd0,
        LANE_CMD_L0      = 2'd1,
        LANE_CMD_DISABLE = 2'd2,
        LANE_CMD_QUIET   = 2'd3
    } lane_cmd_e;

    localparam int unsigned C_CNT_W = 16;

    function automatic logic [4:0] pow2_floor(input logic [4:0] n);
        if (n >= 5'd16)     return 5'd16;
        else if (n >= 5'd8) return 5'd8;
        else if (n >= 5'd4) return 5'd4;
        else if (n >= 5'd2) return 5'd2;
        else if (n >= 5'd1) return 5'd1;
        else                return 5'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ltssm_lane.sv
`default_nettype none
// ============================================================================
// Module : ltssm_lane
// Brief  : Per-lane LTSSM: receiver detect, polling with TS counting, and
//          hand-off to the link arbiter in CONFIG_LINKWIDTH_START.
// Rev    : 1.0
// ============================================================================
module ltssm_lane
    import ozdefs::*;
#(
    parameter int TS1_REQ      = 16,
    parameter int TS2_REQ      = 16,
    parameter int RX_WAIT      = 4,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txdetectrx,
    input  logic [1:0] powerdown,
    input  logic       txelecidle,
    input  logic       ts1_seen,
    input  logic       ts2_seen,
    input  lane_cmd_e  cmd,
    output logic       phystatus,
    output logic [2:0] rxstatus,
    output logic       rxelecidle,
    output LTSSM_State lane_state
);

    LTSSM_State         r_state_q,      w_state_d;
    logic [C_CNT_W-1:0] r_ts1_cnt_q,    w_ts1_cnt_d;
    logic [C_CNT_W-1:0] r_ts2_cnt_q,    w_ts2_cnt_d;
    logic [C_CNT_W-1:0] r_tmo_cnt_q,    w_tmo_cnt_d;
    logic [C_CNT_W-1:0] r_dwell_cnt_q,  w_dwell_cnt_d;
    logic               r_phystatus_q,  w_phystatus_d;
    logic [2:0]         r_rxstatus_q,   w_rxstatus_d;
    logic               r_rxelecidle_q, w_rxelecidle_d;
    logic               w_exit;
    logic [C_CNT_W-1:0] w_tmo_inc;

    always_comb begin
        w_state_d      = r_state_q;
        w_ts1_cnt_d    = r_ts1_cnt_q;
        w_ts2_cnt_d    = r_ts2_cnt_q;
        w_tmo_cnt_d    = r_tmo_cnt_q;
        w_dwell_cnt_d  = r_dwell_cnt_q;
        w_phystatus_d  = r_phystatus_q;
        w_rxstatus_d   = r_rxstatus_q;
        w_rxelecidle_d = r_rxelecidle_q;
        w_exit         = 1'b0;
        w_tmo_inc      = r_tmo_cnt_q + 16'd1;

        case (r_state_q)
            DETECT_QUIET: begin
                if (txdetectrx) begin
                    w_state_d     = DETECT_ACTIVE;
                    w_phystatus_d = 1'b1;
                    w_rxstatus_d  = 3'd3;
                end else begin
                    w_phystatus_d = 1'b0;
                    w_rxstatus_d  = 3'd0;
                end
            end
            DETECT_ACTIVE: begin
                if (powerdown == 2'b00) begin
                    w_state_d     = POLLING_ACTIVE;
                    w_phystatus_d = 1'b1;
                    w_rxstatus_d  = 3'd0;
                    w_dwell_cnt_d = '0;
                end else begin
                    w_phystatus_d = 1'b0;
                    w_rxstatus_d  = 3'd0;
                end
            end
            POLLING_ACTIVE: begin
                w_rxelecidle_d = 1'b0;
                w_phystatus_d  = 1'b0;
                w_ts1_cnt_d    = '0;
                w_ts2_cnt_d    = '0;
                w_tmo_cnt_d    = '0;
                if (r_dwell_cnt_q == 16'(RX_WAIT)) begin
                    w_state_d     = POLLING_ACTIVE_START_TS1;
                    w_dwell_cnt_d = '0;
                end else begin
                    w_dwell_cnt_d = r_dwell_cnt_q + 16'd1;
                end
            end
            POLLING_ACTIVE_START_TS1, POLLING_CONFIG: begin
                if (ts1_seen && (r_ts1_cnt_q != 16'hFFFF)) w_ts1_cnt_d = r_ts1_cnt_q + 16'd1;
                if (ts2_seen && (r_ts2_cnt_q != 16'hFFFF)) w_ts2_cnt_d = r_ts2_cnt_q + 16'd1;
                w_exit = (r_state_q == POLLING_ACTIVE_START_TS1) ? (r_ts1_cnt_q >= 16'(TS1_REQ))
                                                                 : (r_ts2_cnt_q >= 16'(TS2_REQ));
                // A qualifying exit beats a timeout that lands on the same cycle.
                if (w_exit && !txelecidle) begin
                    w_state_d   = (r_state_q == POLLING_ACTIVE_START_TS1) ? POLLING_CONFIG
                                                                          : CONFIG_LINKWIDTH_START;
                    w_tmo_cnt_d = '0;
                end else if (w_tmo_inc == 16'(POLL_TIMEOUT)) begin
                    w_state_d      = DETECT_QUIET;
                    w_rxelecidle_d = 1'b1;
                    w_tmo_cnt_d    = '0;
                    w_ts1_cnt_d    = '0;
                    w_ts2_cnt_d    = '0;
                end else begin
                    w_tmo_cnt_d = w_tmo_inc;
                end
            end
            DISABLED: begin
                w_rxelecidle_d = 1'b1;
                w_phystatus_d  = 1'b0;
                w_rxstatus_d   = 3'd0;
            end
            default: ;
        endcase

        case (cmd)
            LANE_CMD_L0: begin
                w_state_d = L0;
            end
            LANE_CMD_DISABLE: begin
                w_state_d      = DISABLED;
                w_rxelecidle_d = 1'b1;
                w_phystatus_d  = 1'b0;
                w_rxstatus_d   = 3'd0;
            end
            LANE_CMD_QUIET: begin
                w_state_d      = DETECT_QUIET;
                w_rxelecidle_d = 1'b1;
                w_phystatus_d  = 1'b0;
                w_rxstatus_d   = 3'd0;
                w_ts1_cnt_d    = '0;
                w_ts2_cnt_d    = '0;
                w_tmo_cnt_d    = '0;
                w_dwell_cnt_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= DETECT_QUIET;
            r_ts1_cnt_q    <= '0;
            r_ts2_cnt_q    <= '0;
            r_tmo_cnt_q    <= '0;
            r_dwell_cnt_q  <= '0;
            r_phystatus_q  <= 1'b0;
            r_rxstatus_q   <= 3'd0;
            r_rxelecidle_q <= 1'b1;
        end else begin
            r_state_q      <= w_state_d;
            r_ts1_cnt_q    <= w_ts1_cnt_d;
            r_ts2_cnt_q    <= w_ts2_cnt_d;
            r_tmo_cnt_q    <= w_tmo_cnt_d;
            r_dwell_cnt_q  <= w_dwell_cnt_d;
            r_phystatus_q  <= w_phystatus_d;
            r_rxstatus_q   <= w_rxstatus_d;
            r_rxelecidle_q <= w_rxelecidle_d;
        end
    end

    assign phystatus  = r_phystatus_q;
    assign rxstatus   = r_rxstatus_q;
    assign rxelecidle = r_rxelecidle_q;
    assign lane_state = r_state_q;

endmodule
`default_nettype wire

// File: rtl/ltssm_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ltssm_ctrl
// Brief  : NLANES per-lane LTSSMs plus link-width arbitration and link status.
// Rev    : 1.0
// ============================================================================
module ltssm_ctrl
    import ozdefs::*;
#(
    parameter int NLANES       = 16,
    parameter int TS1_REQ      = 16,
    parameter int TS2_REQ      = 16,
    parameter int RX_WAIT      = 4,
    parameter int POLL_TIMEOUT = 1024,
    parameter int CFG_WAIT     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NLANES-1:0]     txdetectrx,
    input  logic [2*NLANES-1:0]   powerdown,
    input  logic [NLANES-1:0]     txelecidle,
    input  logic [NLANES-1:0]     ts1_seen,
    input  logic [NLANES-1:0]     ts2_seen,
    output logic [NLANES-1:0]     phystatus,
    output logic [3*NLANES-1:0]   rxstatus,
    output logic [NLANES-1:0]     rxelecidle,
    output logic [4*NLANES-1:0]   lane_state,
    output logic [NLANES-1:0]     lane_active,
    output logic                  link_up,
    output logic [4:0]            link_width
);

    LTSSM_State         w_lane_state [NLANES];
    lane_cmd_e          w_cmd        [NLANES];
    logic               w_any_cls;
    logic               w_run_open;
    logic               w_decide;
    logic               w_link_down;
    logic [4:0]         w_run;
    logic [4:0]         w_width;
    logic [C_CNT_W-1:0] w_elapsed;

    logic               r_cfg_run_q,     w_cfg_run_d;
    logic [C_CNT_W-1:0] r_cfg_cnt_q,     w_cfg_cnt_d;
    logic               r_link_up_q,     w_link_up_d;
    logic [4:0]         r_link_width_q,  w_link_width_d;
    logic [NLANES-1:0]  r_lane_active_q, w_lane_active_d;

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            ltssm_lane #(
                .TS1_REQ      (TS1_REQ),
                .TS2_REQ      (TS2_REQ),
                .RX_WAIT      (RX_WAIT),
                .POLL_TIMEOUT (POLL_TIMEOUT)
            ) u_lane (
                .clk        (clk),
                .reset      (reset),
                .txdetectrx (txdetectrx[gi]),
                .powerdown  (powerdown[2*gi +: 2]),
                .txelecidle (txelecidle[gi]),
                .ts1_seen   (ts1_seen[gi]),
                .ts2_seen   (ts2_seen[gi]),
                .cmd        (w_cmd[gi]),
                .phystatus  (phystatus[gi]),
                .rxstatus   (rxstatus[3*gi +: 3]),
                .rxelecidle (rxelecidle[gi]),
                .lane_state (w_lane_state[gi])
            );
            assign lane_state[4*gi +: 4] = w_lane_state[gi];
        end
    endgenerate

    // Width is the contiguous run of waiting lanes from lane 0, rounded down to a power of two.
    always_comb begin
        w_any_cls  = 1'b0;
        w_run_open = 1'b1;
        w_run      = 5'd0;
        for (int i = 0; i < NLANES; i++) begin
            if (w_lane_state[i] == CONFIG_LINKWIDTH_START) w_any_cls = 1'b1;
            if (w_run_open && (w_lane_state[i] == CONFIG_LINKWIDTH_START)) w_run = w_run + 5'd1;
            else                                                           w_run_open = 1'b0;
        end
        w_width     = pow2_floor(w_run);
        w_elapsed   = r_cfg_run_q ? r_cfg_cnt_q : '0;
        w_decide    = w_any_cls && (w_elapsed == 16'(CFG_WAIT - 1));
        w_link_down = r_link_up_q && txelecidle[0];
    end

    always_comb begin
        w_cfg_run_d     = r_cfg_run_q;
        w_cfg_cnt_d     = r_cfg_cnt_q;
        w_link_up_d     = r_link_up_q;
        w_link_width_d  = r_link_width_q;
        w_lane_active_d = r_lane_active_q;
        for (int i = 0; i < NLANES; i++) w_cmd[i] = LANE_CMD_NONE;

        if (w_link_down) begin
            w_link_up_d     = 1'b0;
            w_link_width_d  = 5'd0;
            w_lane_active_d = '0;
            w_cfg_run_d     = 1'b0;
            w_cfg_cnt_d     = '0;
            for (int i = 0; i < NLANES; i++) w_cmd[i] = LANE_CMD_QUIET;
        end else if (w_decide) begin
            w_cfg_run_d = 1'b0;
            w_cfg_cnt_d = '0;
            if (w_lane_state[0] == CONFIG_LINKWIDTH_START) begin
                w_link_up_d    = 1'b1;
                w_link_width_d = w_width;
                for (int i = 0; i < NLANES; i++) begin
                    w_lane_active_d[i] = (5'(i) < w_width);
                    w_cmd[i]           = (5'(i) < w_width) ? LANE_CMD_L0 : LANE_CMD_DISABLE;
                end
            end else begin
                for (int i = 0; i < NLANES; i++) w_cmd[i] = LANE_CMD_QUIET;
            end
        end else if (w_any_cls) begin
            w_cfg_run_d = 1'b1;
            w_cfg_cnt_d = r_cfg_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_run_q     <= 1'b0;
            r_cfg_cnt_q     <= '0;
            r_link_up_q     <= 1'b0;
            r_link_width_q  <= 5'd0;
            r_lane_active_q <= '0;
        end else begin
            r_cfg_run_q     <= w_cfg_run_d;
            r_cfg_cnt_q     <= w_cfg_cnt_d;
            r_link_up_q     <= w_link_up_d;
            r_link_width_q  <= w_link_width_d;
            r_lane_active_q <= w_lane_active_d;
        end
    end

    assign link_up     = r_link_up_q;
    assign link_width  = r_link_width_q;
    assign lane_active = r_lane_active_q;

endmodule
`default_nettype wire

// File: tb/tb_ltssm_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ltssm_ctrl
// Brief  : Self-checking bench for ltssm_ctrl with randomized TS traffic.
// Rev    : 1.0
// ============================================================================
module tb_ltssm_ctrl;
    import ozdefs::*;

    localparam int NL  = 16;
    localparam int T1  = 16;
    localparam int T2  = 16;
    localparam int RXW = 4;
    localparam int PTO = 1024;
    localparam int CW  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NL-1:0]   txdetectrx, txelecidle, ts1_seen, ts2_seen;
    logic [2*NL-1:0] powerdown;
    logic [NL-1:0]   phystatus, rxelecidle, lane_active;
    logic [3*NL-1:0] rxstatus;
    logic [4*NL-1:0] lane_state;
    logic            link_up;
    logic [4:0]      link_width;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ltssm_ctrl #(
        .NLANES(NL), .TS1_REQ(T1), .TS2_REQ(T2), .RX_WAIT(RXW),
        .POLL_TIMEOUT(PTO), .CFG_WAIT(CW)
    ) dut (
        .clk(clk), .reset(reset), .txdetectrx(txdetectrx), .powerdown(powerdown),
        .txelecidle(txelecidle), .ts1_seen(ts1_seen), .ts2_seen(ts2_seen),
        .phystatus(phystatus), .rxstatus(rxstatus), .rxelecidle(rxelecidle),
        .lane_state(lane_state), .lane_active(lane_active), .link_up(link_up),
        .link_width(link_width)
    );

    function automatic logic [4*NL-1:0] fill(input logic [NL-1:0] m, input LTSSM_State on,
                                             input LTSSM_State off);
        logic [4*NL-1:0] v;
        for (int i = 0; i < NL; i++) v[4*i +: 4] = m[i] ? on : off;
        return v;
    endfunction

    task automatic idle_inputs();
        txdetectrx = '0; txelecidle = '0; ts1_seen = '0; ts2_seen = '0; powerdown = '1;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++; if (rxelecidle !== 16'hFFFF) $display("FAIL reset_rxelecidle: got %h expected ffff", rxelecidle); else n_pass++;
        n_checks++; if (phystatus !== '0) $display("FAIL reset_phystatus: got %h expected 0", phystatus); else n_pass++;
        n_checks++; if (rxstatus !== '0) $display("FAIL reset_rxstatus: got %h expected 0", rxstatus); else n_pass++;
        n_checks++; if (lane_active !== '0) $display("FAIL reset_lane_active: got %h expected 0", lane_active); else n_pass++;
        n_checks++; if (link_up !== 1'b0) $display("FAIL reset_link_up: got %b expected 0", link_up); else n_pass++;
        n_checks++; if (link_width !== 5'd0) $display("FAIL reset_link_width: got %0d expected 0", link_width); else n_pass++;
        n_checks++; if (lane_state !== '0) $display("FAIL reset_lane_state: got %h expected 0", lane_state); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_detect();
        do_reset();
        txdetectrx = 16'h0008;
        @(negedge clk);
        n_checks++; if (phystatus[3] !== 1'b1) $display("FAIL detect_phystatus: got %b expected 1", phystatus[3]); else n_pass++;
        n_checks++; if (rxstatus[11:9] !== 3'd3) $display("FAIL detect_rxstatus: got %0d expected 3", rxstatus[11:9]); else n_pass++;
        n_checks++; if (lane_state[15:12] !== DETECT_ACTIVE) $display("FAIL detect_state: got %0d expected %0d", lane_state[15:12], DETECT_ACTIVE); else n_pass++;
        txdetectrx = '0;
        @(negedge clk);
        n_checks++; if ({phystatus[3], rxstatus[11:9], lane_state[15:12]} !== {1'b0, 3'd0, DETECT_ACTIVE})
            $display("FAIL detect_hold: got phy=%b rxs=%0d st=%0d expected 0 0 %0d", phystatus[3], rxstatus[11:9], lane_state[15:12], DETECT_ACTIVE);
        else n_pass++;
        powerdown[7:6] = 2'b00;
        @(negedge clk);
        n_checks++; if ({phystatus[3], lane_state[15:12]} !== {1'b1, POLLING_ACTIVE})
            $display("FAIL detect_to_polling: got phy=%b st=%0d expected 1 %0d", phystatus[3], lane_state[15:12], POLLING_ACTIVE);
        else n_pass++;
        @(negedge clk);
        n_checks++; if ({phystatus[3], rxelecidle[3]} !== 2'b00)
            $display("FAIL polling_outputs: got phy=%b rxei=%b expected 0 0", phystatus[3], rxelecidle[3]);
        else n_pass++;
    endtask

    // Walks the lanes in mask from DETECT_QUIET into POLLING_ACTIVE_START_TS1.
    task automatic bring_to_ts1(input logic [NL-1:0] mask);
        powerdown  = '1;
        txdetectrx = mask;
        @(negedge clk);
        n_checks++; if (lane_state !== fill(mask, DETECT_ACTIVE, DETECT_QUIET))
            $display("FAIL bring_detect: got %h expected %h", lane_state, fill(mask, DETECT_ACTIVE, DETECT_QUIET));
        else n_pass++;
        txdetectrx = '0;
        for (int i = 0; i < NL; i++) if (mask[i]) powerdown[2*i +: 2] = 2'b00;
        @(negedge clk);
        for (int k = 0; k <= RXW + 1; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (lane_state !== fill(mask, (k == RXW + 1) ? POLLING_ACTIVE_START_TS1 : POLLING_ACTIVE, DETECT_QUIET))
                $display("FAIL bring_polling k=%0d: got %h expected %h", k, lane_state,
                         fill(mask, (k == RXW + 1) ? POLLING_ACTIVE_START_TS1 : POLLING_ACTIVE, DETECT_QUIET));
            else n_pass++;
        end
    endtask

    // Random-gap TS1 traffic; a lane leaves one cycle after its T1-th pulse is counted.
    task automatic ts1_phase(input logic [NL-1:0] mask);
        int sent [NL];
        int done_e [NL];
        logic [4*NL-1:0] exp_st;
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < NL; i++) begin sent[i] = 0; done_e[i] = -1; end
        for (int e = 0; e < 400 && !all_done; e++) begin
            for (int i = 0; i < NL; i++) begin
                ts1_seen[i] = mask[i] && (sent[i] < T1) && ($urandom_range(0, 1) == 1);
                if (ts1_seen[i]) begin
                    sent[i]++;
                    if (sent[i] == T1) done_e[i] = e;
                end
            end
            @(negedge clk);
            all_done = 1'b1;
            for (int i = 0; i < NL; i++) begin
                if (!mask[i]) exp_st[4*i +: 4] = DETECT_QUIET;
                else if (done_e[i] >= 0 && e >= done_e[i] + 1) exp_st[4*i +: 4] = POLLING_CONFIG;
                else begin exp_st[4*i +: 4] = POLLING_ACTIVE_START_TS1; all_done = 1'b0; end
            end
            n_checks++; if (lane_state !== exp_st) $display("FAIL ts1_progress e=%0d: got %h expected %h", e, lane_state, exp_st); else n_pass++;
        end
        ts1_seen = '0;
        if (!all_done) begin
            n_checks++; $display("FAIL ts1_budget: got not-done expected all lanes in POLLING_CONFIG");
        end
    endtask

    // Simultaneous TS2 burst, then the width decision computed from the trained mask.
    task automatic ts2_decide(input logic [NL-1:0] mask);
        int run, w;
        logic [NL-1:0]   exp_act;
        logic [4*NL-1:0] exp_st;
        ts2_seen = mask;
        repeat (T2) @(negedge clk);
        ts2_seen = '0;
        n_checks++; if (lane_state !== fill(mask, POLLING_CONFIG, DETECT_QUIET))
            $display("FAIL ts2_still_pcfg: got %h expected %h", lane_state, fill(mask, POLLING_CONFIG, DETECT_QUIET));
        else n_pass++;
        @(negedge clk);
        n_checks++; if (lane_state !== fill(mask, CONFIG_LINKWIDTH_START, DETECT_QUIET))
            $display("FAIL ts2_enter_cfg: got %h expected %h", lane_state, fill(mask, CONFIG_LINKWIDTH_START, DETECT_QUIET));
        else n_pass++;
        repeat (CW - 1) @(negedge clk);
        n_checks++; if ({link_up, lane_state} !== {1'b0, fill(mask, CONFIG_LINKWIDTH_START, DETECT_QUIET)})
            $display("FAIL cfg_wait_early: got up=%b st=%h expected up=0 st=%h", link_up, lane_state, fill(mask, CONFIG_LINKWIDTH_START, DETECT_QUIET));
        else n_pass++;
        @(negedge clk);
        run = 0;
        for (int i = 0; i < NL; i++) if (mask[i] && run == i) run++;
        w = 0;
        if (run > 0) begin w = 1; while (w * 2 <= run) w = w * 2; end
        for (int i = 0; i < NL; i++) begin
            exp_act[i] = (i < w);
            if (run == 0)   exp_st[4*i +: 4] = DETECT_QUIET;
            else if (i < w) exp_st[4*i +: 4] = L0;
            else            exp_st[4*i +: 4] = DISABLED;
        end
        n_checks++; if (link_up !== (run > 0)) $display("FAIL decide_link_up mask=%h: got %b expected %b", mask, link_up, run > 0); else n_pass++;
        n_checks++; if (link_width !== 5'(w)) $display("FAIL decide_width mask=%h: got %0d expected %0d", mask, link_width, w); else n_pass++;
        n_checks++; if (lane_active !== exp_act) $display("FAIL decide_active mask=%h: got %h expected %h", mask, lane_active, exp_act); else n_pass++;
        n_checks++; if (lane_state !== exp_st) $display("FAIL decide_state mask=%h: got %h expected %h", mask, lane_state, exp_st); else n_pass++;
        n_checks++; if (rxelecidle !== ~exp_act) $display("FAIL decide_rxelecidle mask=%h: got %h expected %h", mask, rxelecidle, ~exp_act); else n_pass++;
    endtask

    task automatic test_full_width();
        do_reset();
        bring_to_ts1('1);
        ts1_phase('1);
        ts2_decide('1);
        n_checks++; if ({link_up, link_width, lane_active} !== {1'b1, 5'd16, 16'hFFFF})
            $display("FAIL full_width: got up=%b w=%0d act=%h expected 1 16 ffff", link_up, link_width, lane_active);
        else n_pass++;
    endtask

    task automatic test_link_down();
        txelecidle[0] = 1'b1;
        @(negedge clk);
        txelecidle[0] = 1'b0;
        n_checks++; if (lane_state !== '0) $display("FAIL linkdown_state: got %h expected 0", lane_state); else n_pass++;
        n_checks++; if ({link_up, link_width, lane_active} !== '0)
            $display("FAIL linkdown_status: got up=%b w=%0d act=%h expected 0 0 0", link_up, link_width, lane_active);
        else n_pass++;
        n_checks++; if (rxelecidle !== 16'hFFFF) $display("FAIL linkdown_rxelecidle: got %h expected ffff", rxelecidle); else n_pass++;
    endtask

    task automatic test_partial();
        do_reset();
        bring_to_ts1(16'h003F);
        ts1_phase(16'h003F);
        ts2_decide(16'h003F);
        n_checks++; if ({link_width, lane_active, lane_state[23:16]} !== {5'd4, 16'h000F, DISABLED, DISABLED})
            $display("FAIL partial_width: got w=%0d act=%h st45=%h expected 4 000f 77", link_width, lane_active, lane_state[23:16]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        bring_to_ts1(16'h0004);
        for (int k = 1; k <= PTO; k++) begin
            ts1_seen[2] = (k <= T1 - 1);
            @(negedge clk);
            if (k == PTO - 1) begin
                n_checks++; if ({lane_state[11:8], rxelecidle[2]} !== {POLLING_ACTIVE_START_TS1, 1'b0})
                    $display("FAIL timeout_early: got st=%0d rxei=%b expected %0d 0", lane_state[11:8], rxelecidle[2], POLLING_ACTIVE_START_TS1);
                else n_pass++;
            end
        end
        ts1_seen = '0;
        n_checks++; if ({lane_state[11:8], rxelecidle[2]} !== {DETECT_QUIET, 1'b1})
            $display("FAIL timeout_quiet: got st=%0d rxei=%b expected 0 1", lane_state[11:8], rxelecidle[2]);
        else n_pass++;
    endtask

    task automatic test_reset_in_pcfg();
        do_reset();
        bring_to_ts1('1);
        ts1_phase('1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if ({link_up, lane_state} !== '0) $display("FAIL reset_pcfg: got up=%b st=%h expected 0 0", link_up, lane_state); else n_pass++;
        n_checks++; if (rxelecidle !== 16'hFFFF) $display("FAIL reset_pcfg_rxei: got %h expected ffff", rxelecidle); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [NL-1:0] mask;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            mask = 16'($urandom);
            if (mask == '0) mask = 16'h0001;
            bring_to_ts1(mask);
            ts1_phase(mask);
            ts2_decide(mask);
            test_link_down();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_detect();
        test_full_width();
        test_link_down();
        test_partial();
        test_timeout();
        test_reset_in_pcfg();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ltssm_ctrl.md
LTSSM_CTRL -- requirements
Module: ltssm_ctrl

Interface
REQ-001 Parameter NLANES, default 16: number of lanes; legal values are 1, 2, 4, 8 and 16.
REQ-002 Parameter TS1_REQ, default 16: TS1 count needed to leave POLLING_ACTIVE_START_TS1.
REQ-003 Parameter TS2_REQ, default 16: TS2 count needed to leave POLLING_CONFIG.
REQ-004 Parameter RX_WAIT, default 4: dwell cycles in POLLING_ACTIVE.
REQ-005 Parameter POLL_TIMEOUT, default 1024: cycles allowed in either polling-TS state before returning to DETECT_QUIET.
REQ-006 Parameter CFG_WAIT, default 8: cycles from the first lane entering CONFIG_LINKWIDTH_START to the link-width decision.
REQ-007 There SHALL be one clock; reset is synchronous and active-high.
REQ-008 Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- txdetectrx  in  NLANES  receiver-detect request, per lane.
- powerdown  in  2*NLANES  lane i at bits [2i+1:2i].
- txelecidle  in  NLANES  MAC electrical idle.
- ts1_seen  in  NLANES  one-cycle pulse per TS1 received.
- ts2_seen  in  NLANES  one-cycle pulse per TS2 received.
- phystatus  out  NLANES.
- rxstatus  out  3*NLANES.
- rxelecidle  out  NLANES.
- lane_state  out  4*NLANES  encoded per-lane state.
- lane_active  out  NLANES  lane is a member of the trained link.
- link_up  out  1.
- link_width  out  5  number of trained lanes, 0 when the link is down.

Function
REQ-009 Each lane SHALL have its own FSM with states DETECT_QUIET, DETECT_ACTIVE, POLLING_ACTIVE, POLLING_ACTIVE_START_TS1, POLLING_CONFIG, CONFIG_LINKWIDTH_START, L0 and DISABLED.
REQ-010 DETECT_QUIET behaviour:
- txdetectrx[i]=1: next cycle phystatus[i]=1, rxstatus=3, state DETECT_ACTIVE.
- otherwise: phystatus[i]=0, rxstatus=0.
REQ-011 DETECT_ACTIVE behaviour:
- powerdown==0: next cycle phystatus[i]=1, state POLLING_ACTIVE.
- otherwise: phystatus[i]=0, rxstatus=0.
REQ-012 POLLING_ACTIVE behaviour:
- drive rxelecidle[i]=0 and phystatus[i]=0;
- clear the lane's TS1 counter, TS2 counter and timeout counter;
- after RX_WAIT+1 cycles, go to POLLING_ACTIVE_START_TS1.
REQ-013 The TS1 and TS2 counters SHALL be 16 bits wide, increment once per seen pulse, and saturate at 0xFFFF.
REQ-014 POLLING_ACTIVE_START_TS1 SHALL go to POLLING_CONFIG when ts1cnt>=TS1_REQ and txelecidle[i]=0, and SHALL clear the timeout counter on that transition.
REQ-015 POLLING_CONFIG SHALL go to CONFIG_LINKWIDTH_START when ts2cnt>=TS2_REQ and txelecidle[i]=0.
REQ-016 Timeout: when the timeout counter reaches POLL_TIMEOUT in either polling-TS state, the lane SHALL go to DETECT_QUIET with rxelecidle[i]=1; if exit and timeout occur in the same cycle, exit wins.
REQ-017 Width decision, made CFG_WAIT cycles after the first lane enters CONFIG_LINKWIDTH_START:
- N = run of consecutive CONFIG_LINKWIDTH_START lanes starting at lane 0;
- width = largest power of two <= N;
- lanes [0,width) go to L0 with lane_active=1, and link_up=1 and link_width=width are set;
- all other lanes go to DISABLED;
- if lane 0 is not in CONFIG_LINKWIDTH_START, every lane goes to DETECT_QUIET.
REQ-018 DISABLED SHALL hold rxelecidle=1, phystatus=0 and rxstatus=0 until reset or link-down.
REQ-019 Link-down: txelecidle[0]=1 while in L0 SHALL, on the next cycle, clear link_up, link_width and lane_active, and send every lane (including DISABLED lanes) to DETECT_QUIET.

Reset
REQ-020 On reset, every lane SHALL be in DETECT_QUIET with all counters at 0, phystatus=0, rxstatus=0, rxelecidle all ones, lane_active=0, link_up=0 and link_width=0.
REQ-021 Reset SHALL take effect from any state, including in the middle of polling or L0, on the next clk edge.

Structure
REQ-022 The LTSSM_State enum and its 4-bit encoding SHALL live in the shared ozdefs package.
REQ-023 The per-lane FSM and its counters SHALL be one sub-module, ltssm_lane, instantiated NLANES times; width arbitration and link status SHALL sit in ltssm_ctrl.

Verification
REQ-024 Reset for 2 cycles -> rxelecidle=16'hFFFF, every other output 0, every lane_state=DETECT_QUIET.
REQ-025 txdetectrx[3]=1 for one cycle -> next cycle phystatus[3]=1 and rxstatus lane 3=3; then powerdown3=0 -> phystatus[3]=1 and state POLLING_ACTIVE.
REQ-026 All 16 lanes receive 16 TS1 then 16 TS2 -> CFG_WAIT cycles later link_up=1, link_width=16, lane_active=16'hFFFF.
REQ-027 Only lanes 0-5 are trained -> link_width=4, lanes 4-5 DISABLED, lane_active=16'h000F.
REQ-028 Lane 2 receives 15 TS1 then stalls -> exactly POLL_TIMEOUT cycles after entering the state, lane 2 is in DETECT_QUIET with rxelecidle[2]=1.
REQ-029 Reset asserted in POLLING_CONFIG, and txelecidle[0]=1 asserted in L0 -> every lane in DETECT_QUIET and link_up=0 on the next cycle in both cases.
